// File: rtl/updown_counter_ctrl.sv
// Sequencer and checker for an external 8-bit up/down counter: it loads a start value,
// ramps the counter to a target and compares every returned count with its own expectation.
module updown_counter_ctrl #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 300
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] start_val,
   input  logic [WIDTH-1:0] target_val,
   output logic             cnt_en,
   output logic             cnt_m,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_data,
   input  logic [WIDTH-1:0] cnt_count,
   output logic             busy,
   output logic             done,
   output logic             error
);

   // state    | meaning
   // S_IDLE   | waiting for start; counter interface quiet
   // S_LOAD   | load strobe with latched start value
   // S_VERIFY | check the counter took the start value
   // S_RUN    | counter enabled, every returned count checked
   // S_DONE   | one-cycle done pulse
   // S_ERR    | one-cycle error state; error flag already set
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_VERIFY, S_RUN, S_DONE, S_ERR
   } state_e;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic             dir_q, dir_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             error_q, error_d;
   logic [WIDTH-1:0] next_exp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         start_q  <= '0;
         target_q <= '0;
         exp_q    <= '0;
         dir_q    <= 1'b0;
         tmo_q    <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         target_q <= target_d;
         exp_q    <= exp_d;
         dir_q    <= dir_d;
         tmo_q    <= tmo_d;
         error_q  <= error_d;
      end
   end

   assign next_exp = dir_q ? (exp_q - 1'b1) : (exp_q + 1'b1);
   assign error    = error_q;

   // error is raised on the transition into S_ERR so it is already visible during S_ERR
   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      target_d = target_q;
      exp_d    = exp_q;
      dir_d    = dir_q;
      tmo_d    = tmo_q;
      error_d  = error_q;
      cnt_en   = 1'b0;
      cnt_m    = 1'b0;
      cnt_load = 1'b0;
      cnt_data = '0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               start_d  = start_val;
               target_d = target_val;
               error_d  = 1'b0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            busy     = 1'b1;
            cnt_load = 1'b1;
            cnt_data = start_q;
            state_d  = S_VERIFY;
         end
         S_VERIFY: begin
            busy = 1'b1;
            if (cnt_count != start_q) begin
               error_d = 1'b1;
               state_d = S_ERR;
            end else if (cnt_count == target_q) begin
               state_d = S_DONE;
            end else begin
               dir_d   = (target_q < start_q);
               exp_d   = start_q;
               tmo_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            busy   = 1'b1;
            cnt_en = 1'b1;
            cnt_m  = dir_q;
            if (cnt_count != exp_q) begin
               error_d = 1'b1;
               state_d = S_ERR;
            end else begin
               exp_d = next_exp;
               tmo_d = tmo_q + 1'b1;
               if (next_exp == target_q) begin
                  state_d = S_DONE;
               end else if (tmo_q == TMO_LAST) begin
                  error_d = 1'b1;
                  state_d = S_ERR;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Directed bench for updown_counter_ctrl with a behavioural up/down counter attached.
module tb_updown_counter_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] start_val;
   logic [7:0] target_val;
   logic       cnt_en;
   logic       cnt_m;
   logic       cnt_load;
   logic [7:0] cnt_data;
   logic [7:0] cnt_count;
   logic       busy;
   logic       done;
   logic       error;

   logic [7:0] model_q;
   logic       fault;

   int total = 0;
   int bad   = 0;

   // results of the most recent run
   int         r_done_c;
   int         r_err_c;
   int         r_en;
   int         r_load;
   int         r_load_data;
   int         r_m_bad;
   int         r_seq_bad;
   int         r_final;

   updown_counter_ctrl #(.WIDTH(8), .TIMEOUT(300)) dut (
      .clk(clk), .rst(rst), .start(start), .start_val(start_val), .target_val(target_val),
      .cnt_en(cnt_en), .cnt_m(cnt_m), .cnt_load(cnt_load), .cnt_data(cnt_data),
      .cnt_count(cnt_count), .busy(busy), .done(done), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           model_q <= 8'd0;
      else if (cnt_load) model_q <= cnt_data;
      else if (cnt_en)   model_q <= cnt_m ? model_q - 8'd1 : model_q + 8'd1;
   end

   assign cnt_count = (fault && cnt_en) ? 8'd3 : model_q;

   // Issue one start, then observe cycle by cycle (c=1 is the cycle after the accepting edge)
   // until done or error shows up, or max cycles elapse.
   task automatic do_run(input logic [7:0] sv, input logic [7:0] tv, input int max, input int mid_c);
      logic dir;
      dir = (tv < sv);
      r_done_c = 0; r_err_c = 0; r_en = 0; r_load = 0; r_load_data = -1;
      r_m_bad = 0; r_seq_bad = 0; r_final = -1;
      @(negedge clk);
      start = 1'b1; start_val = sv; target_val = tv;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= max; c++) begin
         @(negedge clk);
         if (cnt_load) begin
            r_load++;
            r_load_data = int'(cnt_data);
         end
         if (cnt_en) begin
            if (cnt_m !== dir) r_m_bad++;
            if (cnt_count !== (dir ? sv - 8'(r_en) : sv + 8'(r_en))) r_seq_bad++;
            r_en++;
         end
         if (c == mid_c) begin
            start = 1'b1; start_val = 8'd1; target_val = 8'd2;
         end
         if (c == mid_c + 1) start = 1'b0;
         if (done === 1'b1 && r_done_c == 0) r_done_c = c;
         if (error === 1'b1 && r_err_c == 0) r_err_c = c;
         if (r_done_c != 0 || r_err_c != 0) begin
            r_final = int'(cnt_count);
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      total++;
      if ({cnt_en, cnt_m, cnt_load, cnt_data, busy, done, error} !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 0", {cnt_en, cnt_m, cnt_load, cnt_data, busy, done, error});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({cnt_en, cnt_load, busy, done, error} !== 5'd0) begin
         bad++;
         $display("FAIL reset_idle: got %b want 0", {cnt_en, cnt_load, busy, done, error});
      end
   endtask

   task automatic test_up();
      do_run(8'd5, 8'd8, 20, -10);
      total++;
      if (r_done_c !== 6) begin bad++; $display("FAIL up_done_cycle: got %0d want 6", r_done_c); end
      total++;
      if (r_en !== 3) begin bad++; $display("FAIL up_en_cycles: got %0d want 3", r_en); end
      total++;
      if (r_load !== 1 || r_load_data !== 5) begin
         bad++; $display("FAIL up_load: got %0d cycles data %0d want 1 cycle data 5", r_load, r_load_data);
      end
      total++;
      if (r_m_bad !== 0 || r_seq_bad !== 0) begin
         bad++; $display("FAIL up_sequence: got m_bad=%0d seq_bad=%0d want 0/0", r_m_bad, r_seq_bad);
      end
      total++;
      if (r_final !== 8 || r_err_c !== 0) begin
         bad++; $display("FAIL up_final: got count %0d err_c %0d want 8/0", r_final, r_err_c);
      end
   endtask

   task automatic test_down();
      do_run(8'd9, 8'd6, 20, -10);
      total++;
      if (r_done_c !== 6) begin bad++; $display("FAIL down_done_cycle: got %0d want 6", r_done_c); end
      total++;
      if (r_en !== 3 || r_m_bad !== 0 || r_seq_bad !== 0) begin
         bad++; $display("FAIL down_steps: got en=%0d m_bad=%0d seq_bad=%0d want 3/0/0", r_en, r_m_bad, r_seq_bad);
      end
      total++;
      if (r_final !== 6) begin bad++; $display("FAIL down_final: got %0d want 6", r_final); end
   endtask

   task automatic test_equal();
      do_run(8'd42, 8'd42, 20, -10);
      total++;
      if (r_done_c !== 3) begin bad++; $display("FAIL equal_done_cycle: got %0d want 3", r_done_c); end
      total++;
      if (r_en !== 0 || r_load !== 1 || r_load_data !== 42) begin
         bad++; $display("FAIL equal_activity: got en=%0d load=%0d data=%0d want 0/1/42", r_en, r_load, r_load_data);
      end
   endtask

   task automatic test_full_range();
      do_run(8'd0, 8'd255, 300, 20);
      total++;
      if (r_done_c !== 258) begin bad++; $display("FAIL full_done_cycle: got %0d want 258", r_done_c); end
      total++;
      if (r_en !== 255 || r_seq_bad !== 0 || r_m_bad !== 0) begin
         bad++; $display("FAIL full_steps: got en=%0d seq_bad=%0d m_bad=%0d want 255/0/0", r_en, r_seq_bad, r_m_bad);
      end
      total++;
      if (r_final !== 255 || r_err_c !== 0) begin
         bad++; $display("FAIL full_final: got %0d err_c %0d want 255/0", r_final, r_err_c);
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || cnt_load !== 1'b0) begin
         bad++; $display("FAIL busy_start_ignored: got busy=%b load=%b want 0/0", busy, cnt_load);
      end
   endtask

   task automatic test_fault();
      fault = 1'b1;
      do_run(8'd0, 8'd10, 20, -10);
      total++;
      if (r_err_c !== 4 || r_done_c !== 0) begin
         bad++; $display("FAIL fault_error_cycle: got err_c=%0d done_c=%0d want 4/0", r_err_c, r_done_c);
      end
      total++;
      if (cnt_en !== 1'b0) begin bad++; $display("FAIL fault_en_drop: got %b want 0", cnt_en); end
      fault = 1'b0;
      @(negedge clk);
      total++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL fault_sticky: got error=%b busy=%b want 1/0", error, busy);
      end
      do_run(8'd1, 8'd3, 20, -10);
      total++;
      if (r_err_c !== 0 || r_done_c !== 5) begin
         bad++; $display("FAIL fault_clear: got err_c=%0d done_c=%0d want 0/5", r_err_c, r_done_c);
      end
   endtask

   task automatic test_back_to_back();
      int loads;
      int second_c;
      loads = 0;
      second_c = 0;
      @(negedge clk);
      start = 1'b1; start_val = 8'd5; target_val = 8'd6;
      @(posedge clk);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (cnt_load) begin
            loads++;
            if (loads == 2) begin second_c = c; break; end
         end
      end
      start = 1'b0;
      total++;
      if (second_c !== 6) begin bad++; $display("FAIL b2b_restart_cycle: got %0d want 6", second_c); end
      for (int c = 0; c < 20 && busy; c++) @(negedge clk);
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || error !== 1'b0 || model_q !== 8'd6) begin
         bad++; $display("FAIL b2b_settle: got busy=%b error=%b count=%0d want 0/0/6", busy, error, model_q);
      end
   endtask

   task automatic test_rst_mid();
      @(negedge clk);
      start = 1'b1; start_val = 8'd0; target_val = 8'd200;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (12) @(negedge clk);
      total++;
      if (cnt_en !== 1'b1) begin bad++; $display("FAIL rst_mid_running: got en=%b want 1", cnt_en); end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({cnt_en, cnt_m, cnt_load, cnt_data, busy, done, error} !== 13'd0) begin
         bad++; $display("FAIL rst_mid_outputs: got %b want 0", {cnt_en, cnt_m, cnt_load, cnt_data, busy, done, error});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || cnt_en !== 1'b0) begin
         bad++; $display("FAIL rst_mid_idle: got busy=%b en=%b want 0/0", busy, cnt_en);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_val = 8'd0; target_val = 8'd0; fault = 1'b0;
      test_reset();
      test_up();
      test_down();
      test_equal();
      test_full_range();
      test_fault();
      test_back_to_back();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
